// File: rtl/counter_sched.sv
// Round-robin scheduler that lends one CW-bit up-counter to NREQ requesters.
// Define COUNTER_SCHED_ABORT_EN to add a synchronous abort input for the COUNT state.
module counter_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 4,
    parameter int IDW  = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
`ifdef COUNTER_SCHED_ABORT_EN
    input  logic               abort,
`endif
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*CW-1:0] req_count,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [IDW-1:0]     grant_id,
    output logic [CW-1:0]      count_out
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     target_q, target_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              found;
    logic [IDW-1:0]    winner;
    logic              abort_w;

`ifdef COUNTER_SCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Search starts at rr_q and wraps, so the most recent owner is considered last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(rr_q) + k) % NREQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && state_q == S_IDLE && found)
            req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        busy_d   = busy_q;
        done_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    target_d = req_count[int'(winner)*CW +: CW];
                    grant_d  = winner;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    rr_d     = IDW'((int'(winner) + 1) % NREQ);
                    state_d  = S_COUNT;
                end
            end
            S_COUNT: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else if (enable) begin
                    if (count_q == target_q) begin
                        state_d         = S_DONE;
                        done_d[grant_q] = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            target_q <= '0;
            grant_q  <= '0;
            rr_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign count_out = count_q;

endmodule
